// File: rtl/game_score_scheduler.sv
// game_score_scheduler
//  Feeds the BCD score counter one point at a time. Frame ticks (divided down)
//  and bonus pickups credit a saturating pending-point counter; the FSM drains
//  it as isolated 1-cycle inc_en pulses, each followed by a low gap, so the
//  counter's edge detector sees exactly one increment per pulse.
//
// Ports
//  clk           clock
//  resetn        synchronous, active-low reset
//  gameState     game FSM state (menu clears, running credits/drains, else frozen)
//  frame_tick    1-cycle pulse per video frame
//  bonus_req     1-cycle bonus pickup strobe
//  bonus_amount  points added with bonus_req (0 = no-op)
//  inc_en        increment pulse to the score counter
//  pending       points credited but not yet issued
//  overflow      sticky flag: a credit was clipped by saturation
//  busy          FSM not idle or points still pending

`ifndef GAME_MENU
`define GAME_MENU 4'd0
`endif
`ifndef GAME_RUNNING
`define GAME_RUNNING 4'd1
`endif
`ifndef GAME_OVER
`define GAME_OVER 4'd2
`endif

module game_score_scheduler #(
    parameter int FRAMES_PER_POINT = 6,
    parameter int PEND_W           = 6,
    parameter int GAP_CYCLES       = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [3:0]        gameState,
    input  logic              frame_tick,
    input  logic              bonus_req,
    input  logic [3:0]        bonus_amount,
    output logic              inc_en,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    output logic              busy
);

    localparam int DIV_W = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int SUM_W = PEND_W + 5;

    localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'((2 ** PEND_W) - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAMES_PER_POINT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic              clear;
    logic              running;
    logic              fcredit;
    logic [3:0]        bcredit;
    logic              dec;
    logic [SUM_W-1:0]  sum;

    assign clear   = !resetn || (gameState == `GAME_MENU);
    assign running = (gameState == `GAME_RUNNING);

    // Credit sources, decrement and the single saturating adder. Outside
    // Running every term is zero, so pending, divider and overflow hold.
    // The pending!=0 guard on dec keeps the adder from wrapping below zero.
    always_comb begin
        div_d   = div_q;
        fcredit = 1'b0;
        bcredit = 4'd0;
        dec     = 1'b0;

        if (running && frame_tick) begin
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                fcredit = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        if (running && bonus_req) begin
            bcredit = bonus_amount;
        end

        if ((state_q == PULSE) && running && (pending_q != '0)) begin
            dec = 1'b1;
        end

        sum = {5'b0, pending_q}
            + {{(SUM_W-1){1'b0}}, fcredit}
            + {{(SUM_W-4){1'b0}}, bcredit}
            - {{(SUM_W-1){1'b0}}, dec};

        overflow_d = overflow_q;
        if (sum > PEND_MAX) begin
            pending_d  = PEND_MAX[PEND_W-1:0];
            overflow_d = 1'b1;
        end else begin
            pending_d = sum[PEND_W-1:0];
        end
    end

    // Pulse sequencer: one PULSE cycle, GAP_CYCLES low cycles, then back to
    // IDLE, which costs one more cycle before the next pulse can start.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;

        unique case (state_q)
            IDLE: begin
                if (running && (pending_q != '0)) begin
                    state_d = PULSE;
                end
            end
            PULSE: begin
                state_d = GAP;
                gap_d   = GAP_LOAD;
            end
            GAP: begin
                if (gap_q == GAP_ONE) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                gap_d   = '0;
            end
        endcase
    end

    // Menu clear shares the synchronous reset path and beats every other event.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            div_q      <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            div_q      <= div_d;
            gap_q      <= gap_d;
        end
    end

    assign inc_en   = (state_q == PULSE);
    assign pending  = pending_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_game_score_scheduler.sv
// tb_game_score_scheduler
//  Directed bench for game_score_scheduler. Every expected inc_en rising edge
//  is queued (as a cycle number) when its credit is driven; a negedge monitor
//  pops the queue on each rising edge and also checks that pulses are 1 cycle.

`ifndef GAME_MENU
`define GAME_MENU 4'd0
`endif
`ifndef GAME_RUNNING
`define GAME_RUNNING 4'd1
`endif
`ifndef GAME_OVER
`define GAME_OVER 4'd2
`endif

module tb_game_score_scheduler;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] gameState;
    logic       frame_tick;
    logic       bonus_req;
    logic [3:0] bonus_amount;
    logic       inc_en;
    logic [5:0] pending;
    logic       overflow;
    logic       busy;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sb[$];
    int   exp_c;
    int   k;
    logic prev_inc = 1'b0;

    game_score_scheduler dut (
        .clk          (clk),
        .resetn       (resetn),
        .gameState    (gameState),
        .frame_tick   (frame_tick),
        .bonus_req    (bonus_req),
        .bonus_amount (bonus_amount),
        .inc_en       (inc_en),
        .pending      (pending),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (prev_inc === 1'b1) begin
            n_checks++;
            assert (inc_en === 1'b0) else begin
                n_fail++;
                $error("[TB] FAIL pulse_width: inc_en=%b at cycle %0d, required 0", inc_en, cyc);
            end
        end else if (inc_en === 1'b1) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("[TB] FAIL unexpected_pulse: inc_en rose at cycle %0d, no pulse expected", cyc);
            end
            if (sb.size() != 0) begin
                exp_c = sb.pop_front();
                n_checks++;
                assert (cyc === exp_c) else begin
                    n_fail++;
                    $error("[TB] FAIL pulse_cycle: inc_en rose at cycle %0d, required %0d", cyc, exp_c);
                end
            end
        end
        prev_inc <= inc_en;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ft, input logic br, input logic [3:0] amt);
        frame_tick   = ft;
        bonus_req    = br;
        bonus_amount = amt;
        tick();
        frame_tick   = 1'b0;
        bonus_req    = 1'b0;
        bonus_amount = 4'd0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        resetn       = 1'b0;
        gameState    = `GAME_MENU;
        frame_tick   = 1'b0;
        bonus_req    = 1'b0;
        bonus_amount = 4'd0;

        // Reset state
        repeat (3) tick();
        checkOutput("rst_inc_en", 32'(inc_en), 0);
        checkOutput("rst_pending", 32'(pending), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        resetn = 1'b1;
        tick();
        checkOutput("menu_pending", 32'(pending), 0);
        gameState = `GAME_RUNNING;
        tick();

        // Six frame ticks, 10 cycles apart: one point on the sixth
        for (int i = 0; i < 6; i++) begin
            if (i == 5) sb.push_back(cyc + 2);
            applyStimulus(1'b1, 1'b0, 4'd0);
            checkOutput("frame_pending", 32'(pending), (i == 5) ? 1 : 0);
            if (i < 5) repeat (9) tick();
        end
        repeat (9) tick();
        checkOutput("frame_drained", 32'(pending), 0);
        checkOutput("frame_busy", 32'(busy), 0);

        // Bonus of 5 drains as 5 pulses, 4 cycles apart
        k = cyc;
        for (int i = 0; i < 5; i++) sb.push_back(k + 2 + 4 * i);
        applyStimulus(1'b0, 1'b1, 4'd5);
        checkOutput("bonus5_pending", 32'(pending), 5);
        repeat (21) tick();
        checkOutput("bonus5_drained", 32'(pending), 0);
        checkOutput("bonus5_busy", 32'(busy), 0);
        checkOutput("bonus5_overflow", 32'(overflow), 0);

        // Frame credit, bonus 3 and a pulse decrement in one cycle
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("pre_same_pending", 32'(pending), 0);
        k = cyc;
        sb.push_back(k + 2);
        for (int i = 0; i < 5; i++) sb.push_back(k + 6 + 4 * i);
        applyStimulus(1'b0, 1'b1, 4'd2);
        checkOutput("same_base", 32'(pending), 2);
        tick();
        checkOutput("same_in_pulse", 32'(inc_en), 1);
        applyStimulus(1'b1, 1'b1, 4'd3);
        checkOutput("same_pending", 32'(pending), 5);
        repeat (23) tick();
        checkOutput("same_drained", 32'(pending), 0);
        checkOutput("same_busy", 32'(busy), 0);

        // Saturation at 63 with sticky overflow, then a menu clear mid-pulse
        k = cyc;
        sb.push_back(k + 2);
        sb.push_back(k + 6);
        sb.push_back(k + 10);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 4'd15);
        applyStimulus(1'b0, 1'b1, 4'd1);
        checkOutput("sat_pending60", 32'(pending), 60);
        checkOutput("sat_no_ovf", 32'(overflow), 0);
        applyStimulus(1'b0, 1'b1, 4'd9);
        checkOutput("sat_pending63", 32'(pending), 63);
        checkOutput("sat_ovf", 32'(overflow), 1);
        tick();
        checkOutput("sat_after_dec", 32'(pending), 62);
        checkOutput("sat_ovf_sticky", 32'(overflow), 1);
        repeat (3) tick();
        checkOutput("menu_mid_pulse", 32'(inc_en), 1);
        gameState = `GAME_MENU;
        tick();
        checkOutput("menu_inc_en", 32'(inc_en), 0);
        checkOutput("menu_pending", 32'(pending), 0);
        checkOutput("menu_overflow", 32'(overflow), 0);
        checkOutput("menu_busy", 32'(busy), 0);
        gameState = `GAME_RUNNING;
        tick();

        // Freeze during a pulse: no point consumed, credits ignored, then resume
        k = cyc;
        sb.push_back(k + 2);
        applyStimulus(1'b0, 1'b1, 4'd4);
        checkOutput("frz_pending", 32'(pending), 4);
        tick();
        gameState = `GAME_OVER;
        tick();
        checkOutput("frz_no_dec", 32'(pending), 4);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 4'd7);
        checkOutput("frz_hold", 32'(pending), 4);
        checkOutput("frz_overflow", 32'(overflow), 0);
        checkOutput("frz_busy", 32'(busy), 1);
        checkOutput("frz_inc_en", 32'(inc_en), 0);
        tick();
        k = cyc;
        for (int i = 0; i < 4; i++) sb.push_back(k + 1 + 4 * i);
        gameState = `GAME_RUNNING;
        repeat (18) tick();
        checkOutput("resume_drained", 32'(pending), 0);
        checkOutput("resume_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("div_held", 32'(pending), 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) sb.push_back(cyc + 2);
            applyStimulus(1'b1, 1'b0, 4'd0);
        end
        checkOutput("div_wrap", 32'(pending), 1);
        repeat (6) tick();
        checkOutput("div_drained", 32'(pending), 0);

        // resetn low mid-pulse
        k = cyc;
        sb.push_back(k + 2);
        applyStimulus(1'b0, 1'b1, 4'd3);
        tick();
        checkOutput("rstn_mid_pulse", 32'(inc_en), 1);
        resetn = 1'b0;
        tick();
        checkOutput("rstn_inc_en", 32'(inc_en), 0);
        checkOutput("rstn_pending", 32'(pending), 0);
        checkOutput("rstn_busy", 32'(busy), 0);
        resetn = 1'b1;
        repeat (6) tick();
        checkOutput("rstn_stays_idle", 32'(busy), 0);

        checkOutput("scoreboard_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
